// File: rtl/sfx_scheduler_pkg.sv
// rtl/sfx_scheduler_pkg.sv - shared types and constants for the sound-effect scheduler
package sfx_scheduler_pkg;
  localparam int NUM_SFX   = 4;
  localparam int PERIOD_W  = 12;
  localparam int VOL_W     = 4;
  localparam int FRAMES_W  = 4;
  localparam int STEP_W    = 3;
  localparam int COOL_W    = 6;
  localparam int MAX_STEPS = 4;

  localparam logic [1:0] SFX_SHEEP    = 2'd0;
  localparam logic [1:0] SFX_SWORD    = 2'd1;
  localparam logic [1:0] SFX_HURT     = 2'd2;
  localparam logic [1:0] SFX_GAMEOVER = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY} state_e;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic                noise;
    logic [VOL_W-1:0]    vol;
    logic [FRAMES_W-1:0] frames;
  } step_rec_t;

  // Highest set bit wins; game over outranks everything else.
  function automatic logic [1:0] top_pending(input logic [NUM_SFX-1:0] p);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (p[i]) w = 2'(i);
    end
    return w;
  endfunction
endpackage

// File: rtl/sfx_scheduler_if.sv
// rtl/sfx_scheduler_if.sv - voice generator control bus
interface sfx_scheduler_if;
  import sfx_scheduler_pkg::*;

  logic                voice_en;
  logic                voice_noise;
  logic [PERIOD_W-1:0] voice_period;
  logic [VOL_W-1:0]    voice_vol;

  modport master (output voice_en, voice_noise, voice_period, voice_vol);
  modport slave  (input  voice_en, voice_noise, voice_period, voice_vol);
endinterface

// File: rtl/sfx_scheduler_step_rom.sv
// rtl/sfx_scheduler_step_rom.sv - note program table, {id, step} -> step record
module sfx_scheduler_step_rom
  import sfx_scheduler_pkg::*;
(
  input  logic [1:0]        id_i,
  input  logic [STEP_W-1:0] step_i,
  output step_rec_t         rec_o
);
  // A zero frames field marks the end of a program.
  always_comb begin
    rec_o = '0;
    unique case (id_i)
      SFX_SHEEP: if (step_i == 3'd0) rec_o = '{12'd600, 1'b0, 4'd8, 4'd6};
      SFX_SWORD: if (step_i == 3'd0) rec_o = '{12'd0, 1'b1, 4'd10, 4'd3};
      SFX_HURT: begin
        if (step_i == 3'd0) rec_o = '{12'd200, 1'b0, 4'd12, 4'd4};
        if (step_i == 3'd1) rec_o = '{12'd300, 1'b0, 4'd12, 4'd4};
      end
      SFX_GAMEOVER: begin
        case (step_i)
          3'd0:    rec_o = '{12'd600, 1'b0, 4'd14, 4'd8};
          3'd1:    rec_o = '{12'd400, 1'b0, 4'd14, 4'd8};
          3'd2:    rec_o = '{12'd500, 1'b0, 4'd14, 4'd8};
          3'd3:    rec_o = '{12'd700, 1'b0, 4'd14, 4'd8};
          default: rec_o = '0;
        endcase
      end
      default: rec_o = '0;
    endcase
  end
endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - event-driven effect sequencer driving one shared voice
module sfx_scheduler
  import sfx_scheduler_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [NUM_SFX-1:0]   sfx_req,
  sfx_scheduler_if.master      voice,
  output logic                 busy,
  output logic [1:0]           active_id
);
  state_e              state_q;
  logic [NUM_SFX-1:0]  req_q, pending_q, pending_d, rise;
  logic [COOL_W-1:0]   cooldown_q [NUM_SFX];
  logic [COOL_W-1:0]   cooldown_d [NUM_SFX];
  logic [1:0]          id_q, active_id_q, winner;
  logic [STEP_W-1:0]   step_q;
  logic [FRAMES_W-1:0] frame_cnt_q, frames_q;
  logic                en_q, noise_q, start_load;
  logic [PERIOD_W-1:0] period_q;
  logic [VOL_W-1:0]    vol_q;
  step_rec_t           rec;

  sfx_scheduler_step_rom u_rom (.id_i(id_q), .step_i(step_q), .rec_o(rec));

  assign busy   = (state_q != ST_IDLE);
  assign rise   = sfx_req & ~req_q;
  assign winner = top_pending(pending_q);
  // Start a program from idle, or preempt a lower-priority one mid-play.
  assign start_load = (pending_q != '0) &&
                      ((state_q == ST_IDLE) || ((state_q == ST_PLAY) && (winner > id_q)));

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_SFX; i++) begin
      cooldown_d[i] = cooldown_q[i];
      if (frame_tick && cooldown_q[i] != '0) cooldown_d[i] = cooldown_q[i] - 1'b1;
      if (rise[i] && cooldown_q[i] == '0 && !(busy && active_id_q == 2'(i))) pending_d[i] = 1'b1;
      if (start_load && winner == 2'(i)) begin
        pending_d[i]  = 1'b0;
        cooldown_d[i] = COOL_W'(COOLDOWN_FRAMES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      cooldown_q  <= '{default: '0};
      id_q        <= '0;
      active_id_q <= '0;
      step_q      <= '0;
      frame_cnt_q <= '0;
      frames_q    <= '0;
      en_q        <= 1'b0;
      noise_q     <= 1'b0;
      period_q    <= '0;
      vol_q       <= '0;
    end else begin
      req_q      <= sfx_req;
      pending_q  <= pending_d;
      cooldown_q <= cooldown_d;
      unique case (state_q)
        ST_IDLE: begin
          if (start_load) begin
            id_q    <= winner;
            step_q  <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (rec.frames == '0 || step_q == STEP_W'(MAX_STEPS)) begin
            en_q        <= 1'b0;
            noise_q     <= 1'b0;
            period_q    <= '0;
            vol_q       <= '0;
            active_id_q <= '0;
            state_q     <= ST_IDLE;
          end else begin
            en_q        <= 1'b1;
            noise_q     <= rec.noise;
            period_q    <= rec.period;
            vol_q       <= rec.vol;
            frames_q    <= rec.frames;
            active_id_q <= id_q;
            frame_cnt_q <= '0;
            state_q     <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (start_load) begin
            id_q    <= winner;
            step_q  <= '0;
            state_q <= ST_LOAD;
          end else if (frame_tick) begin
            if (frame_cnt_q == frames_q - 4'd1) begin
              step_q  <= step_q + 3'd1;
              state_q <= ST_LOAD;
            end else begin
              frame_cnt_q <= frame_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign voice.voice_en     = en_q;
  assign voice.voice_noise  = noise_q;
  assign voice.voice_period = period_q;
  assign voice.voice_vol    = vol_q;
  assign active_id          = active_id_q;
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - scoreboard bench for sfx_scheduler
module tb_sfx_scheduler;
  import sfx_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] sfx_req = 4'd0;
  logic       busy;
  logic [1:0] active_id;

  sfx_scheduler_if vif ();

  sfx_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .sfx_req(sfx_req),
    .voice(vif.master), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en; bit noise; int period; int vol; int id; int frames;
  } seg_t;

  seg_t sb[$];
  seg_t cur_exp;
  logic [19:0] cur_tuple;
  int   tick_cnt;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  int   ph = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference program table: one entry per note step.
  function automatic int prog_len(input int id);
    case (id)
      0, 1:    return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic seg_t step_of(input int id, input int s);
    seg_t r;
    int   p3 [4];
    p3 = '{600, 400, 500, 700};
    r.en = 1'b1; r.id = id; r.noise = 1'b0;
    case (id)
      0:       begin r.period = 600; r.vol = 8; r.frames = 6; end
      1:       begin r.period = 0; r.noise = 1'b1; r.vol = 10; r.frames = 3; end
      2:       begin r.period = (s == 0) ? 200 : 300; r.vol = 12; r.frames = 4; end
      default: begin r.period = p3[s]; r.vol = 14; r.frames = 8; end
    endcase
    return r;
  endfunction

  function automatic seg_t idle_seg();
    seg_t r;
    r.en = 1'b0; r.noise = 1'b0; r.period = 0; r.vol = 0; r.id = 0; r.frames = -1;
    return r;
  endfunction

  function automatic int total_frames(input int id);
    int t = 0;
    for (int s = 0; s < prog_len(id); s++) t += step_of(id, s).frames;
    return t;
  endfunction

  function automatic int seg_at(input int id, input int k);
    int cum = 0;
    for (int s = 0; s < prog_len(id); s++) begin
      cum += step_of(id, s).frames;
      if (k < cum) return s;
    end
    return prog_len(id) - 1;
  endfunction

  // cut < 0: whole program then silence; otherwise steps 0..cut, last one cut short.
  function automatic void push_prog(input int id, input int cut);
    int   last;
    seg_t e;
    last = (cut < 0) ? prog_len(id) - 1 : cut;
    for (int s = 0; s <= last; s++) begin
      e = step_of(id, s);
      if (s == cut) e.frames = -1;
      sb.push_back(e);
    end
    if (cut < 0) sb.push_back(idle_seg());
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      frame_tick = (ph == 7);
      ph = (ph + 1) % 8;
    end
  end

  always @(negedge clk) begin
    logic [19:0] t;
    seg_t        e;
    if (mon_en) begin
      t = {vif.voice_en, vif.voice_noise, vif.voice_period, vif.voice_vol, active_id};
      if (t != cur_tuple) begin
        if (cur_exp.frames >= 0) check("seg_frames", tick_cnt, cur_exp.frames);
        if (sb.size() == 0) begin
          check("unexpected_change", int'(t), int'(cur_tuple));
          cur_exp = idle_seg();
        end else begin
          e = sb.pop_front();
          check("voice_en", int'(vif.voice_en), int'(e.en));
          check("voice_noise", int'(vif.voice_noise), int'(e.noise));
          check("voice_period", int'(vif.voice_period), e.period);
          check("voice_vol", int'(vif.voice_vol), e.vol);
          check("active_id", int'(active_id), e.id);
          cur_exp = e;
        end
        cur_tuple = t;
        tick_cnt  = 0;
      end
      if (frame_tick) tick_cnt++;
    end
  end

  task automatic wait_ticks(input int n);
    int seen = 0;
    while (seen < n) begin
      @(negedge clk);
      if (frame_tick) seen++;
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    sfx_req = m;
    @(negedge clk);
    sfx_req = 4'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sb.size() == 0 && vif.voice_en == 1'b0 && busy == 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 3000) ? 1 : 0, 1);
    wait_ticks(33);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int kind, a, b, k, hi, lo;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_en", int'(vif.voice_en), 0);
    check("rst_period", int'(vif.voice_period), 0);
    check("rst_vol", int'(vif.voice_vol), 0);
    check("rst_noise", int'(vif.voice_noise), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active_id", int'(active_id), 0);
    cur_tuple = '0;
    cur_exp   = idle_seg();
    tick_cnt  = 0;
    mon_en    = 1'b1;

    for (int f = 0; f < 100;) begin
      @(negedge clk);
      if (frame_tick) f++;
      check("idle_en", int'(vif.voice_en), 0);
      check("idle_busy", int'(busy), 0);
    end

    // Sheep: voice appears exactly three edges after the request.
    push_prog(0, -1);
    @(negedge clk);
    sfx_req = 4'b0001;
    @(negedge clk);
    sfx_req = 4'b0000;
    @(negedge clk);
    check("lat2_en", int'(vif.voice_en), 0);
    @(negedge clk);
    check("lat3_en", int'(vif.voice_en), 1);
    check("lat3_period", int'(vif.voice_period), 600);
    wait_idle();

    push_prog(2, -1);
    pulse(4'b0100);
    wait_idle();

    push_prog(0, seg_at(0, 2));
    push_prog(3, -1);
    pulse(4'b0001);
    wait_ticks(2);
    pulse(4'b1000);
    wait_idle();

    push_prog(1, -1);
    pulse(4'b0010);
    wait_ticks(10);
    pulse(4'b0010);
    wait_ticks(21);
    push_prog(1, -1);
    pulse(4'b0010);
    wait_idle();

    push_prog(1, -1);
    push_prog(0, -1);
    pulse(4'b0011);
    wait_idle();

    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 4));
      a    = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          push_prog(a, -1);
          pulse(4'(1 << a));
        end
        1: begin
          b  = (a + int'($urandom_range(1, 3))) % 4;
          hi = (a > b) ? a : b;
          lo = (a > b) ? b : a;
          push_prog(hi, -1);
          push_prog(lo, -1);
          pulse(4'((1 << a) | (1 << b)));
        end
        2: begin
          a = int'($urandom_range(0, 2));
          b = int'($urandom_range(a + 1, 3));
          k = int'($urandom_range(1, total_frames(a) - 1));
          push_prog(a, seg_at(a, k));
          push_prog(b, -1);
          pulse(4'(1 << a));
          wait_ticks(k);
          pulse(4'(1 << b));
        end
        3: begin
          hi = int'($urandom_range(1, 3));
          lo = int'($urandom_range(0, hi - 1));
          k  = int'($urandom_range(1, total_frames(hi) - 1));
          push_prog(hi, -1);
          push_prog(lo, -1);
          pulse(4'(1 << hi));
          wait_ticks(k);
          pulse(4'(1 << lo));
        end
        default: begin
          k = int'($urandom_range(1, 29));
          push_prog(a, -1);
          pulse(4'(1 << a));
          wait_ticks(k);
          pulse(4'(1 << a));
        end
      endcase
      wait_idle();
    end

    mon_en = 1'b0;
    sb.delete();
    pulse(4'b1000);
    wait_ticks(3);
    @(negedge clk);
    check("pre_reset_en", int'(vif.voice_en), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_en", int'(vif.voice_en), 0);
    check("mid_rst_period", int'(vif.voice_period), 0);
    check("mid_rst_vol", int'(vif.voice_vol), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_active_id", int'(active_id), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_en", int'(vif.voice_en), 0);
    check("post_rst_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
